// File: rtl/hyperbus_resp_pkg.sv
// Shared types, state encodings and decode helpers for the HyperRAM word-level responder.
package hyperbus_resp_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CA    = 3'd1;
  localparam logic [2:0] ST_REGWR = 3'd2;
  localparam logic [2:0] ST_LAT   = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_READ  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CA    = ST_CA,
    REGWR = ST_REGWR,
    LAT   = ST_LAT,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DONE  = ST_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [3:0] lat;
    logic       fixed;
    logic       rsvd;
    logic [1:0] wrap;
  } cr0_t;

  localparam logic [31:0] RegId0 = 32'h0000_0000;
  localparam logic [31:0] RegId1 = 32'h0000_0001;
  localparam logic [31:0] RegCr0 = 32'h0000_0800;
  localparam logic [31:0] RegCr1 = 32'h0000_0801;

  function automatic logic [3:0] lat_decode(input logic [3:0] code);
    case (code)
      4'b0000: lat_decode = 4'd5;
      4'b0001: lat_decode = 4'd6;
      4'b0010: lat_decode = 4'd7;
      4'b1110: lat_decode = 4'd3;
      4'b1111: lat_decode = 4'd4;
      default: lat_decode = 4'd6;
    endcase
  endfunction

  function automatic logic [6:0] wrap_words(input logic [1:0] code);
    case (code)
      2'b00:   wrap_words = 7'd64;
      2'b01:   wrap_words = 7'd32;
      2'b10:   wrap_words = 7'd8;
      default: wrap_words = 7'd16;
    endcase
  endfunction

endpackage

// File: rtl/hyperbus_resp_if.sv
// Word-level HyperBus signal bundle between controller (master) and RAM responder (slave).
interface hyperbus_resp_if;
  logic        cs_ni;
  logic        ck_ena_i;
  logic [15:0] dq_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe_o;
  logic [1:0]  rwds_o;
  logic        rwds_oe_o;

  modport slave (
    input  cs_ni, ck_ena_i, dq_i, rwds_i,
    output dq_o, dq_oe_o, rwds_o, rwds_oe_o
  );

  modport master (
    output cs_ni, ck_ena_i, dq_i, rwds_i,
    input  dq_o, dq_oe_o, rwds_o, rwds_oe_o
  );
endinterface

// File: rtl/hyperbus_resp_mem.sv
// Responder backing store: 16-bit words, asynchronous read, per-byte write enables.
module hyperbus_resp_mem #(
  parameter  int unsigned MemWords = 1024,
  localparam int unsigned AW       = $clog2(MemWords)
) (
  input  logic          clk_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [MemWords];

  always_ff @(posedge clk_i) begin
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hyperbus_ram_responder.sv
// HyperRAM device-side responder: CA decode, 1x/2x initial latency, linear/wrapped bursts
// into local memory, and the ID/CR register space.
module hyperbus_ram_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int unsigned MemWords      = 1024,
  parameter logic [15:0] Cr0Init       = 16'h8F1F,
  parameter logic [15:0] Id0Value      = 16'h0C81,
  parameter logic [15:0] Id1Value      = 16'h0001,
  parameter int unsigned RefreshPeriod = 0,
  parameter int unsigned RefreshWindow = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  hyperbus_resp_if.slave    bus
);

  localparam int unsigned AW = $clog2(MemWords);

  state_e      state_q, state_d;
  cr0_t        cr0_q, cr0_d;
  logic        extra_q, extra_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] ca_q, ca_d;
  logic [4:0]  lat_q, lat_d;
  logic        rd_q, rd_d, reg_q, reg_d, lin_q, lin_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ref_q, ref_d;

  logic        beat;
  logic [1:0]  mem_we;
  logic [15:0] mem_rdata, reg_rdata;
  logic [31:0] wmask, addr_adv;
  logic [4:0]  lat_total;

  assign beat = bus.ck_ena_i & ~bus.cs_ni;

  hyperbus_resp_mem #(.MemWords(MemWords)) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (bus.dq_i),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cr0_d     = cr0_q;
    extra_d   = extra_q;
    cnt_d     = cnt_q;
    ca_d      = ca_q;
    lat_d     = lat_q;
    rd_d      = rd_q;
    reg_d     = reg_q;
    lin_d     = lin_q;
    addr_d    = addr_q;
    mem_we    = '0;
    lat_total = extra_q ? {lat_decode(cr0_q.lat), 1'b0} : {1'b0, lat_decode(cr0_q.lat)};
    wmask     = {25'd0, wrap_words(cr0_q.wrap)} - 32'd1;
    // Wrapped bursts keep the block-aligned upper bits and cycle the offset only.
    if (reg_q)      addr_adv = addr_q;
    else if (lin_q) addr_adv = addr_q + 32'd1;
    else            addr_adv = (addr_q & ~wmask) | ((addr_q + 32'd1) & wmask);

    if (RefreshPeriod != 0)
      ref_d = (ref_q >= RefreshPeriod - 1) ? '0 : ref_q + 32'd1;
    else
      ref_d = '0;

    case (state_q)
      IDLE: if (!bus.cs_ni) begin
        state_d = CA;
        cnt_d   = '0;
        extra_d = cr0_q.fixed | ((RefreshPeriod != 0) && (ref_q < RefreshWindow));
      end
      CA: if (beat) begin
        ca_d  = {ca_q[15:0], bus.dq_i};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          // ca_q holds CA[47:16] here; the current word is CA[15:0].
          rd_d    = ca_q[31];
          reg_d   = ca_q[30];
          lin_d   = ca_q[29];
          addr_d  = {ca_q[28:0], bus.dq_i[2:0]};
          lat_d   = lat_total - 5'd1;
          state_d = (!ca_q[31] && ca_q[30]) ? REGWR : LAT;
        end
      end
      REGWR: if (beat) begin
        if (addr_q == RegCr0) cr0_d = cr0_t'(bus.dq_i);
        state_d = DONE;
      end
      LAT: if (beat) begin
        if (lat_q == 5'd1) state_d = rd_q ? READ : WRITE;
        else               lat_d   = lat_q - 5'd1;
      end
      WRITE: if (beat) begin
        mem_we = ~bus.rwds_i;
        addr_d = addr_adv;
      end
      READ: if (beat) addr_d = addr_adv;
      DONE: ;
      default: state_d = IDLE;
    endcase

    if (bus.cs_ni) state_d = IDLE;
  end

  always_comb begin
    case (addr_q)
      RegId0:  reg_rdata = Id0Value;
      RegId1:  reg_rdata = Id1Value;
      RegCr0:  reg_rdata = cr0_q;
      RegCr1:  reg_rdata = '0;
      default: reg_rdata = '0;
    endcase
  end

  always_comb begin
    bus.dq_o      = '0;
    bus.dq_oe_o   = 1'b0;
    bus.rwds_o    = '0;
    bus.rwds_oe_o = 1'b0;
    if (!bus.cs_ni) begin
      case (state_q)
        CA: begin
          bus.rwds_oe_o = 1'b1;
          bus.rwds_o    = {2{extra_q}};
        end
        LAT: bus.rwds_oe_o = rd_q;
        READ: begin
          bus.dq_oe_o   = 1'b1;
          bus.rwds_oe_o = 1'b1;
          bus.rwds_o    = 2'b10;
          bus.dq_o      = reg_q ? reg_rdata : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cr0_q   <= cr0_t'(Cr0Init);
      extra_q <= 1'b0;
      cnt_q   <= '0;
      ca_q    <= '0;
      lat_q   <= '0;
      rd_q    <= 1'b0;
      reg_q   <= 1'b0;
      lin_q   <= 1'b0;
      addr_q  <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      cr0_q   <= cr0_d;
      extra_q <= extra_d;
      cnt_q   <= cnt_d;
      ca_q    <= ca_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      reg_q   <= reg_d;
      lin_q   <= lin_d;
      addr_q  <= addr_d;
      ref_q   <= ref_d;
    end
  end

endmodule
